// File: rtl/imem_program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Holds the loader state encoding, frame/word field widths and small
// state-classification helpers used by the top-level FSM.
package imem_program_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  // state | meaning
  // IDLE    | after reset, waiting for start
  // LEN_HI  | expecting high byte of word count N
  // LEN_LO  | expecting low byte of N, decides CHECK / ERROR / DATA_HI
  // DATA_HI | expecting high byte of instruction word
  // DATA_LO | expecting low byte; completes a word and issues a write
  // CHECK   | expecting checksum byte
  // DONE    | load good, CPU released
  // ERROR   | oversize length or bad checksum, CPU stays held
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } state_t;

  // States in which a stream byte can be taken.
  function automatic logic takes_bytes(input state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
           (s == ST_DATA_LO) || (s == ST_CHECK);
  endfunction

  // States in which a start pulse begins a new load.
  function automatic logic takes_start(input state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/imem_program_loader_csum.sv
// 8-bit XOR checksum accumulator for the loader payload.
// Ports: clk, rst (async, active high), clr (sync clear, wins over en),
//        en (fold data into acc), data (byte in), acc (running XOR).
module imem_program_loader_csum
  import imem_program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [BYTE_W-1:0] data,
  output logic [BYTE_W-1:0] acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ data;
    end
  end

endmodule

// File: rtl/imem_program_loader.sv
// Writer side of the instruction memory: receives a framed byte stream
// (LEN_HI, LEN_LO, N x {HI, LO}, CSUM), writes the assembled 16-bit words
// sequentially from START_ADDR, verifies the XOR checksum and keeps the CPU
// held until a load finishes cleanly.
// Ports:
//   clk, rst          clock, async active-high reset
//   start             one-cycle load request (honoured in IDLE/DONE/ERROR)
//   in_valid/in_data  byte stream, in_ready = loader accepts this cycle
//   imem_we/addr/wdata instruction-memory write port (registered)
//   cpu_hold          1 = CPU must stall
//   done/error        sticky load result, cleared by an accepted start
//   words_loaded      words written in the current/last load
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                DEPTH      = 256,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [WORD_W-1:0] words_loaded
);

  // One extra bit so a DEPTH of 65536 still compares correctly.
  localparam logic [WORD_W:0] DEPTH_W = (WORD_W+1)'(DEPTH);

  state_t            state;
  logic [WORD_W-1:0] len;
  logic [WORD_W-1:0] word_idx;
  logic [BYTE_W-1:0] hi_byte;
  logic [BYTE_W-1:0] csum_acc;

  logic              xfer;
  logic              start_ok;
  logic [WORD_W-1:0] len_rx;
  logic [WORD_W-1:0] next_idx;

  assign in_ready = takes_bytes(state);
  assign xfer     = in_valid && in_ready;
  assign start_ok = start && takes_start(state);
  assign len_rx   = {len[WORD_W-1:BYTE_W], in_data};
  assign next_idx = word_idx + 16'd1;

  imem_program_loader_csum u_csum (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_ok),
    .en   (xfer && ((state == ST_DATA_HI) || (state == ST_DATA_LO))),
    .data (in_data),
    .acc  (csum_acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      len          <= '0;
      word_idx     <= '0;
      hi_byte      <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= START_ADDR;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state        <= ST_LEN_HI;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            word_idx     <= '0;
          end
        end
        ST_LEN_HI: begin
          if (xfer) begin
            len[WORD_W-1:BYTE_W] <= in_data;
            state                <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (xfer) begin
            len      <= len_rx;
            word_idx <= '0;
            if (len_rx == '0) begin
              state <= ST_CHECK;
            end else if ({1'b0, len_rx} > DEPTH_W) begin
              state <= ST_ERROR;
              error <= 1'b1;
            end else begin
              state <= ST_DATA_HI;
            end
          end
        end
        ST_DATA_HI: begin
          if (xfer) begin
            hi_byte <= in_data;
            state   <= ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (xfer) begin
            imem_we      <= 1'b1;
            imem_addr    <= START_ADDR + ADDR_W'(word_idx);
            imem_wdata   <= {hi_byte, in_data};
            words_loaded <= words_loaded + 16'd1;
            word_idx     <= next_idx;
            state        <= (next_idx == len) ? ST_CHECK : ST_DATA_HI;
          end
        end
        ST_CHECK: begin
          if (xfer) begin
            if (csum_acc == in_data) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
module tb_imem_program_loader;

  localparam int          DEPTH   = 256;
  localparam logic [15:0] T_START = 16'h0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int checks   = 0;
  int failures = 0;

  logic [31:0] got[$];

  imem_program_loader #(
    .ADDR_W(16), .DEPTH(DEPTH), .START_ADDR(T_START)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Capture every write strobe, sampled away from the active edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) got.push_back({imem_addr, imem_wdata});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start_hold", 32'(cpu_hold), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_err", 32'(error), 32'd0);
    chk("start_words", 32'(words_loaded), 32'd0);
    chk("start_ready", 32'(in_ready), 32'd1);
  endtask

  // Offer each byte until taken; gap is the percent chance of idling a cycle.
  task automatic send_bytes(input logic [7:0] q[$], input int gap);
    int idx = 0;
    int budget = 0;
    while (idx < q.size() && budget < 5000) begin
      @(negedge clk);
      in_valid = ($urandom_range(99) >= gap);
      in_data  = in_valid ? q[idx] : 8'($urandom);
      if (in_valid && in_ready) idx++;
      budget++;
    end
    @(negedge clk) in_valid = 1'b0;
    if (idx < q.size()) chk("send_timeout", 32'(idx), 32'(q.size()));
  endtask

  task automatic build(input int n, input bit bad, output logic [7:0] q[$]);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    q.delete();
    q.push_back(8'(n >> 8));
    q.push_back(8'(n));
    if (n > DEPTH) return;
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom);
      x ^= b;
      q.push_back(b);
    end
    q.push_back(bad ? (x ^ 8'(1 + $urandom_range(254))) : x);
  endtask

  // Reference: derive the full expected outcome from the frame bytes alone.
  task automatic run_frame(input string tag, input logic [7:0] q[$], input int gap);
    int n;
    bit exp_err, exp_done;
    logic [7:0] x;
    n = {q[0], q[1]};
    got.delete();
    send_bytes(q, gap);
    repeat (2) @(negedge clk);
    exp_err = (n > DEPTH);
    x = 8'h00;
    if (!exp_err) for (int i = 0; i < 2 * n; i++) x ^= q[2 + i];
    exp_done = !exp_err && (x == q[2 + 2 * n]);
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_err"}, 32'(error), 32'(!exp_done));
    chk({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
    chk({tag, "_words"}, 32'(words_loaded), exp_err ? 32'd0 : 32'(n));
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_nwr"}, 32'(got.size()), exp_err ? 32'd0 : 32'(n));
    if (!exp_err) begin
      for (int k = 0; k < n && k < got.size(); k++)
        chk({tag, "_wr"}, got[k], {16'(T_START + 16'(k)), q[2 + 2 * k], q[3 + 2 * k]});
      if (n > 0) chk({tag, "_hold_addr"}, 32'(imem_addr), 32'(T_START + 16'(n - 1)));
    end
  endtask

  initial begin
    logic [7:0] q[$];
    int n, r;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'(T_START));
    chk("rst_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_flags", {30'd0, done, error}, 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd0);

    // Normal two-word load, checksum derived from payload (12^34^AB^CD).
    do_start();
    q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_frame("normal", q, 0);

    // Start from DONE reloads; bad checksum writes both words then errors.
    do_start();
    q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h3F};
    run_frame("badcs", q, 0);

    // Oversize length: 257 > DEPTH.
    do_start();
    q = '{8'h01, 8'h01};
    run_frame("oversize", q, 0);

    // Exactly DEPTH words is legal.
    do_start();
    build(DEPTH, 1'b0, q);
    run_frame("full", q, 10);

    // Zero length with heavy backpressure.
    do_start();
    q = '{8'h00, 8'h00, 8'h00};
    run_frame("zero", q, 50);

    // Start mid-frame is ignored.
    do_start();
    got.delete();
    q = '{8'h00, 8'h01};
    send_bytes(q, 0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("ign_ready", 32'(in_ready), 32'd1);
    q = '{8'h55, 8'h66, 8'h33};
    send_bytes(q, 0);
    repeat (2) @(negedge clk);
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_nwr", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("ign_wr", got[0], {T_START, 16'h5566});

    // Async reset mid-frame.
    do_start();
    q = '{8'h00, 8'h03, 8'h11, 8'h22};
    send_bytes(q, 0);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("mrst_ready", 32'(in_ready), 32'd0);
    chk("mrst_we", 32'(imem_we), 32'd0);
    chk("mrst_addr", 32'(imem_addr), 32'(T_START));
    chk("mrst_wdata", 32'(imem_wdata), 32'd0);
    chk("mrst_hold", 32'(cpu_hold), 32'd1);
    chk("mrst_flags", {30'd0, done, error}, 32'd0);
    chk("mrst_words", 32'(words_loaded), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("mrst_idle", 32'(in_ready), 32'd0);
    do_start();
    q = '{8'h00, 8'h01, 8'hC3, 8'h5A, 8'h99};
    run_frame("post_rst", q, 20);

    // Randomised frames.
    for (int it = 0; it < 12; it++) begin
      r = $urandom_range(9);
      if (r < 7)       n = $urandom_range(6);
      else if (r == 7) n = DEPTH + 1;
      else if (r == 8) n = $urandom_range(65535, DEPTH + 2);
      else             n = $urandom_range(DEPTH, DEPTH - 3);
      build(n, ($urandom_range(3) == 0), q);
      do_start();
      run_frame("rand", q, $urandom_range(60));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
